// File: rtl/mem_stage.sv
// MEM stage: word-organised data memory with byte/half/word loads and stores, pass-through to M_WB,
// and a debug dump engine.
module mem_stage #(
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = "data_mem.hex"
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [31:0] i_m_alu_result,
  input  logic [31:0] i_m_write_data,
  input  logic        i_m_mem_read,
  input  logic        i_m_mem_write,
  input  logic [1:0]  i_m_width,
  input  logic        i_m_unsigned,
  input  logic [4:0]  i_m_rd,
  input  logic        i_m_mem_to_reg,
  input  logic        i_m_reg_write,
  input  logic        i_m_isJal,
  input  logic [31:0] i_m_pc_plus_8,
  input  logic        i_m_halt,
  output logic [31:0] o_m_read_data,
  output logic [4:0]  o_m_rd,
  output logic        o_m_mem_to_reg,
  output logic        o_m_reg_write,
  output logic        o_m_isJal,
  output logic [31:0] o_m_pc_plus_8,
  output logic        o_m_halt,
  output logic [31:0] o_m_alu_result,
  output logic        o_m_misaligned,
  input  logic        i_du_dump_start,
  input  logic        i_du_ready,
  output logic [31:0] o_du_data,
  output logic        o_du_valid,
  output logic        o_du_busy,
  output logic        o_du_done,
  output logic [1:0]  o_du_state
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_FIN} du_state_t;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              misaligned;
  logic              store_en;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       wr_word;
  du_state_t         du_state, du_state_next;
  logic [ADDR_W-1:0] du_idx;
  logic              unused_addr_bits;

  assign o_m_rd         = i_m_rd;
  assign o_m_mem_to_reg = i_m_mem_to_reg;
  assign o_m_reg_write  = i_m_reg_write;
  assign o_m_isJal      = i_m_isJal;
  assign o_m_pc_plus_8  = i_m_pc_plus_8;
  assign o_m_halt       = i_m_halt;
  assign o_m_alu_result = i_m_alu_result;
  assign o_du_state     = du_state;

  // Upper address bits are ignored so accesses wrap modulo the memory size.
  assign word_idx         = i_m_alu_result[ADDR_W+1:2];
  assign lane             = i_m_alu_result[1:0];
  assign unused_addr_bits = &{1'b0, i_m_alu_result[31:ADDR_W+2]};

  // Width 2'b10 is reserved and behaves as a word access.
  assign misaligned = (i_m_width == 2'b01) ? lane[0] :
                      (i_m_width[1])       ? (lane != 2'b00) : 1'b0;
  assign store_en   = i_clk_en && i_m_mem_write && !misaligned && !o_du_busy;
  assign rd_word    = mem[word_idx];
  assign shifted    = rd_word >> {lane, 3'b000};

  always_comb begin
    o_m_read_data = '0;
    if (i_m_mem_read && !misaligned) begin
      case (i_m_width)
        2'b00:   o_m_read_data = {{24{~i_m_unsigned & shifted[7]}}, shifted[7:0]};
        2'b01:   o_m_read_data = {{16{~i_m_unsigned & shifted[15]}}, shifted[15:0]};
        default: o_m_read_data = rd_word;
      endcase
    end
  end

  always_comb begin
    wr_word = rd_word;
    case (i_m_width)
      2'b00:   wr_word[{lane, 3'b000} +: 8]        = i_m_write_data[7:0];
      2'b01:   wr_word[{lane[1], 4'b0000} +: 16]  = i_m_write_data[15:0];
      default: wr_word = i_m_write_data;
    endcase
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Memory is deliberately outside the reset domain: reset never alters contents.
  always_ff @(posedge i_clk) begin
    if (store_en) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_m_misaligned <= 1'b0;
    else if (i_clk_en && (i_m_mem_read || i_m_mem_write) && misaligned) o_m_misaligned <= 1'b1;
  end

  // Dump handshake: a word transfers on a clock edge where o_du_valid and i_du_ready are both high;
  // o_du_data and o_du_valid stay stable until that edge.
  always_comb begin
    du_state_next = du_state;
    case (du_state)
      S_IDLE:  if (i_du_dump_start && !i_clk_en) du_state_next = S_READ;
      S_READ:  du_state_next = S_SEND;
      S_SEND:  if (i_du_ready) du_state_next = (du_idx == LAST_IDX) ? S_FIN : S_READ;
      S_FIN:   du_state_next = S_IDLE;
      default: du_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      du_state   <= S_IDLE;
      du_idx     <= '0;
      o_du_data  <= '0;
      o_du_valid <= 1'b0;
      o_du_busy  <= 1'b0;
      o_du_done  <= 1'b0;
    end else begin
      du_state   <= du_state_next;
      o_du_valid <= (du_state_next == S_SEND);
      o_du_busy  <= (du_state_next == S_READ) || (du_state_next == S_SEND);
      o_du_done  <= (du_state_next == S_FIN);
      if (du_state == S_READ) o_du_data <= mem[du_idx];
      if (du_state == S_IDLE && du_state_next == S_READ) du_idx <= '0;
      else if (du_state == S_SEND && i_du_ready && du_idx != LAST_IDX) du_idx <= du_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a DEPTH=256 instance for load/store checks and a DEPTH=4 instance for dumps.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [31:0] alu = '0, wdata = '0, pc8 = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, uns = 1'b0;
  logic [1:0]  width = 2'b11;
  logic [4:0]  rd = '0;
  logic        m2r = 1'b0, rw = 1'b0, jal = 1'b0, halt = 1'b0;
  logic        start = 1'b0, ready = 1'b0;

  logic [31:0] b_read_data, b_pc8, b_alu, b_du_data;
  logic [4:0]  b_rd;
  logic        b_m2r, b_rw, b_jal, b_halt, b_mis, b_du_valid, b_du_busy, b_du_done;
  logic [1:0]  b_du_state;
  logic [31:0] s_read_data, s_pc8, s_alu, s_du_data;
  logic [4:0]  s_rd;
  logic        s_m2r, s_rw, s_jal, s_halt, s_mis, s_du_valid, s_du_busy, s_du_done;
  logic [1:0]  s_du_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_m_alu_result(alu), .i_m_write_data(wdata),
    .i_m_mem_read(mem_read), .i_m_mem_write(mem_write), .i_m_width(width), .i_m_unsigned(uns),
    .i_m_rd(rd), .i_m_mem_to_reg(m2r), .i_m_reg_write(rw), .i_m_isJal(jal), .i_m_pc_plus_8(pc8),
    .i_m_halt(halt), .o_m_read_data(b_read_data), .o_m_rd(b_rd), .o_m_mem_to_reg(b_m2r),
    .o_m_reg_write(b_rw), .o_m_isJal(b_jal), .o_m_pc_plus_8(b_pc8), .o_m_halt(b_halt),
    .o_m_alu_result(b_alu), .o_m_misaligned(b_mis), .i_du_dump_start(1'b0), .i_du_ready(1'b0),
    .o_du_data(b_du_data), .o_du_valid(b_du_valid), .o_du_busy(b_du_busy), .o_du_done(b_du_done),
    .o_du_state(b_du_state)
  );

  mem_stage #(.DEPTH(4)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_m_alu_result(alu), .i_m_write_data(wdata),
    .i_m_mem_read(mem_read), .i_m_mem_write(mem_write), .i_m_width(width), .i_m_unsigned(uns),
    .i_m_rd(rd), .i_m_mem_to_reg(m2r), .i_m_reg_write(rw), .i_m_isJal(jal), .i_m_pc_plus_8(pc8),
    .i_m_halt(halt), .o_m_read_data(s_read_data), .o_m_rd(s_rd), .o_m_mem_to_reg(s_m2r),
    .o_m_reg_write(s_rw), .o_m_isJal(s_jal), .o_m_pc_plus_8(s_pc8), .o_m_halt(s_halt),
    .o_m_alu_result(s_alu), .o_m_misaligned(s_mis), .i_du_dump_start(start), .i_du_ready(ready),
    .o_du_data(s_du_data), .o_du_valid(s_du_valid), .o_du_busy(s_du_busy), .o_du_done(s_du_done),
    .o_du_state(s_du_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w);
    @(negedge clk);
    alu = addr; wdata = data; width = w; mem_write = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] w,
                          input logic u, input logic [31:0] exp);
    @(negedge clk);
    alu = addr; width = w; uns = u; mem_read = 1'b1;
    #1;
    check_val(tag, b_read_data, exp);
    mem_read = 1'b0; uns = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    int got, stall, dn;
    logic timed_out;

    // Reset state
    #3;
    check_val("rst_misaligned", {31'b0, b_mis}, 32'h0);
    check_val("rst_read_data", b_read_data, 32'h0);
    check_val("rst_du_valid", {31'b0, s_du_valid}, 32'h0);
    check_val("rst_du_busy", {31'b0, s_du_busy}, 32'h0);
    check_val("rst_du_done", {31'b0, s_du_done}, 32'h0);
    check_val("rst_du_data", s_du_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pass-through
    rd = 5'h15; m2r = 1'b1; rw = 1'b1; jal = 1'b1; halt = 1'b1; pc8 = 32'h0040_0008; alu = 32'hCAFE_0010;
    #1;
    check_val("pt_rd", {27'b0, b_rd}, 32'h15);
    check_val("pt_flags", {28'b0, b_m2r, b_rw, b_jal, b_halt}, 32'hF);
    check_val("pt_pc8", b_pc8, 32'h0040_0008);
    check_val("pt_alu", b_alu, 32'hCAFE_0010);

    // Word store, byte/half loads
    store(32'h10, 32'hA1B2_C3D4, 2'b11);
    load_chk("lw_10", 32'h10, 2'b11, 1'b0, 32'hA1B2_C3D4);
    load_chk("lb_13", 32'h13, 2'b00, 1'b0, 32'hFFFF_FFA1);
    load_chk("lbu_13", 32'h13, 2'b00, 1'b1, 32'h0000_00A1);
    load_chk("lb_10", 32'h10, 2'b00, 1'b0, 32'hFFFF_FFD4);
    load_chk("lbu_11", 32'h11, 2'b00, 1'b1, 32'h0000_00C3);
    load_chk("lh_12", 32'h12, 2'b01, 1'b0, 32'hFFFF_A1B2);
    load_chk("lw_w10", 32'h10, 2'b10, 1'b0, 32'hA1B2_C3D4);
    @(negedge clk); alu = 32'h10; width = 2'b11; mem_read = 1'b0; #1;
    check_val("no_read_zero", b_read_data, 32'h0);

    // Half and byte stores touch only their lanes
    store(32'h22, 32'h5555_8001, 2'b01);
    load_chk("lw_20_sh", 32'h20, 2'b11, 1'b0, 32'h8001_0000);
    load_chk("lh_22", 32'h22, 2'b01, 1'b0, 32'hFFFF_8001);
    load_chk("lhu_22", 32'h22, 2'b01, 1'b1, 32'h0000_8001);
    store(32'h21, 32'h1234_567F, 2'b00);
    load_chk("lw_20_sb", 32'h20, 2'b11, 1'b0, 32'h8001_7F00);
    load_chk("lb_21", 32'h21, 2'b00, 1'b0, 32'h0000_007F);
    load_chk("lh_20", 32'h20, 2'b01, 1'b0, 32'h0000_7F00);

    // Frozen pipeline blocks stores
    clk_en = 1'b0;
    store(32'h30, 32'hDEAD_BEEF, 2'b11);
    clk_en = 1'b1;
    load_chk("lw_30_frozen", 32'h30, 2'b11, 1'b0, 32'h0);

    // Address wrap
    store(32'd1032, 32'hCAFE_F00D, 2'b11);
    load_chk("lw_alias_8", 32'h8, 2'b11, 1'b0, 32'hCAFE_F00D);
    load_chk("lw_alias_1032", 32'd1032, 2'b11, 1'b0, 32'hCAFE_F00D);

    // Read during write returns old contents
    @(negedge clk);
    alu = 32'h10; wdata = 32'h1111_1111; width = 2'b11; mem_write = 1'b1; mem_read = 1'b1;
    #1;
    check_val("rdw_old", b_read_data, 32'hA1B2_C3D4);
    @(negedge clk); mem_write = 1'b0; mem_read = 1'b0;
    load_chk("rdw_new", 32'h10, 2'b11, 1'b0, 32'h1111_1111);
    check_val("mis_still_clear", {31'b0, b_mis}, 32'h0);

    // Misaligned accesses
    store(32'h11, 32'h0000_FFFF, 2'b01);
    check_val("mis_set", {31'b0, b_mis}, 32'h1);
    load_chk("mis_sh_nowrite", 32'h10, 2'b11, 1'b0, 32'h1111_1111);
    store(32'h15, 32'h9999_9999, 2'b11);
    load_chk("mis_sw_nowrite", 32'h14, 2'b11, 1'b0, 32'h0);
    load_chk("mis_lw_zero", 32'h15, 2'b11, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    check_val("mis_sticky", {31'b0, b_mis}, 32'h1);

    // Dump: words 1..4, stall on the second word
    store(32'h0, 32'h1, 2'b11);
    store(32'h4, 32'h2, 2'b11);
    store(32'h8, 32'h3, 2'b11);
    store(32'hC, 32'h4, 2'b11);
    @(negedge clk); clk_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("start_ignored_en", {31'b0, s_du_busy}, 32'h0);
    clk_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("dump_busy", {31'b0, s_du_busy}, 32'h1);
    clk_en = 1'b1; alu = 32'hC; wdata = 32'h0000_0BAD; width = 2'b11; mem_write = 1'b1;
    @(negedge clk); mem_write = 1'b0; clk_en = 1'b0;
    exp_q = {32'h1, 32'h2, 32'h3, 32'h4};
    got = 0; stall = 0; dn = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (s_du_valid) begin
        if (got == 1 && stall < 3) begin
          ready = 1'b0;
          check_val("dump_hold", s_du_data, 32'h2);
          stall++;
        end else begin
          ready = 1'b1;
          check_val("dump_word", s_du_data, exp_q.pop_front());
          got++;
        end
      end else ready = 1'b0;
      @(negedge clk);
      if (s_du_done) dn++;
    end
    ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (s_du_done) dn++;
    end
    check_val("dump_count", got, 32'd4);
    check_val("dump_stalls", stall, 32'd3);
    check_val("dump_done_once", dn, 32'd1);
    check_val("dump_busy_end", {31'b0, s_du_busy}, 32'h0);
    check_val("dump_valid_end", {31'b0, s_du_valid}, 32'h0);

    // Reset during SEND of the second word
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0; timed_out = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (s_du_valid && got == 1) begin
        timed_out = 1'b0;
        break;
      end
      if (s_du_valid) begin
        ready = 1'b1;
        got++;
      end else ready = 1'b0;
      @(negedge clk);
    end
    ready = 1'b0;
    check_val("rst_mid_reached", {31'b0, timed_out}, 32'h0);
    check_val("rst_mid_word", s_du_data, 32'h2);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_valid", {31'b0, s_du_valid}, 32'h0);
    check_val("rst_mid_busy", {31'b0, s_du_busy}, 32'h0);
    check_val("rst_mid_done", {31'b0, s_du_done}, 32'h0);
    check_val("rst_clears_mis", {31'b0, b_mis}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_val("rst_no_done", {31'b0, s_du_done}, 32'h0);

    // Restarted dump begins at word 0
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (s_du_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check_val("restart_valid", {31'b0, timed_out}, 32'h0);
    check_val("restart_word0", s_du_data, 32'h1);
    ready = 1'b1;
    repeat (20) @(negedge clk);
    ready = 1'b0;
    check_val("restart_busy_end", {31'b0, s_du_busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
